// File: rtl/mont_pkg.sv
// mont_pkg: shared state encoding, default width and counter sizing for the serial Montgomery multiplier
package mont_pkg;
  typedef enum logic [1:0] {IDLE, LOOP, FINAL, DONE} mont_state_t;
  localparam int MONT_WIDTH = 128;
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/mont_iter.sv
// mont_iter: one radix-2 Montgomery step, s_next = (s + a_bit*b + q*m) / 2 with q making the sum even
//   s      in  WIDTH+2  running accumulator
//   b, m   in  WIDTH    multiplier and odd modulus
//   a_bit  in  1        current multiplicand bit
//   s_next out WIDTH+2  accumulator for the next iteration
module mont_iter #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH+1:0] s,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  input  logic             a_bit,
  output logic [WIDTH+1:0] s_next
);
  logic [WIDTH+1:0] t, u;
  assign t = s + (a_bit ? {2'b00, b} : '0);
  // adding the odd modulus to an odd sum makes it even, so the shift is exact
  assign u = t + (t[0] ? {2'b00, m} : '0);
  assign s_next = u >> 1;
endmodule

// File: rtl/montgomery_mul_serial.sv
// montgomery_mul_serial: bit-serial R = A*B*2^-WIDTH mod M with valid/ready on both sides
//   clock, reset              rising-edge clock, synchronous active-high reset
//   io_in_valid/io_in_ready   operand handshake; io_A, io_B, io_M latched on accept
//   io_out_valid/io_out_ready result handshake; io_R held stable while waiting
//   io_err                    operand-illegal flag, present only with MONT_ERR_CHECK_EN
module montgomery_mul_serial
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  input  logic [WIDTH-1:0] io_M,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_R
`ifdef MONT_ERR_CHECK_EN
  ,
  output logic             io_err
`endif
);
  localparam int CW = cnt_width(WIDTH);
  mont_state_t state;
  logic [WIDTH-1:0] a, b, m, r;
  logic [WIDTH+1:0] s, s_next;
  logic [CW-1:0] cnt;
  mont_iter #(.WIDTH(WIDTH)) u_iter (
    .s(s),
    .b(b),
    .m(m),
    .a_bit(a[0]),
    .s_next(s_next)
  );
  assign io_in_ready = state == IDLE;
  assign io_out_valid = state == DONE;
  assign io_R = r;
`ifdef MONT_ERR_CHECK_EN
  logic err, bad;
  assign bad = ~io_M[0] | (io_A >= io_M) | (io_B >= io_M);
  assign io_err = err;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      r <= '0;
      cnt <= '0;
`ifdef MONT_ERR_CHECK_EN
      err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (io_in_valid) begin
          a <= io_A;
          b <= io_B;
          m <= io_M;
          s <= '0;
          cnt <= '0;
`ifdef MONT_ERR_CHECK_EN
          // illegal operands skip the loop and report a zero result
          state <= bad ? DONE : LOOP;
          err <= bad;
          if (bad) r <= '0;
`else
          state <= LOOP;
`endif
        end
        LOOP: begin
          s <= s_next;
          a <= a >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FINAL;
        end
        FINAL: begin
          // S < 2M here, so one conditional subtract completes the reduction
          r <= (s >= {2'b00, m}) ? WIDTH'(s - {2'b00, m}) : s[WIDTH-1:0];
          state <= DONE;
        end
        DONE: if (io_out_ready) begin
          state <= IDLE;
`ifdef MONT_ERR_CHECK_EN
          err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/montgomery_mul_serial.md
# montgomery_mul_serial

Parametrised radix-2 bit-serial Montgomery modular multiplier computing R = A·B·2^-WIDTH mod M for WIDTH-bit operands. It is the generalised successor of the fixed 128-bit multiplier core driven by `test_multiply`. It adds a runtime modulus, a valid/ready handshake on both sides and an optional operand-legality check. It sits between the operand generator and the result checker in the self-test harness.

## Interface
- `WIDTH`, 128: operand, modulus and result width in bits; legal range ≥ 4.
- `clock`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `io_in_valid`  in  1  operand set valid.
- `io_in_ready`  out  1  core can accept operands.
- `io_A`  in  WIDTH  multiplicand; requires A < M.
- `io_B`  in  WIDTH  multiplier; requires B < M.
- `io_M`  in  WIDTH  modulus; requires odd M.
- `io_out_valid`  out  1  result valid.
- `io_out_ready`  in  1  consumer accepts result.
- `io_R`  out  WIDTH  result, A·B·2^-WIDTH mod M.
- `io_err`  out  1  operand-illegal flag; exists only with `MONT_ERR_CHECK_EN`.

## Operation
- States and transitions:
  - IDLE to LOOP on `io_in_valid & io_in_ready`; A, B and M are latched and the accumulator S is cleared.
  - LOOP to FINAL after WIDTH iterations.
  - FINAL to DONE.
  - DONE to IDLE on `io_out_valid & io_out_ready`.
- `io_in_ready` = (state == IDLE). `io_out_valid` = (state == DONE).
- One LOOP iteration per cycle, i = 0..WIDTH-1, LSB of A first:
  - S ← S + a_i·B
  - if S is odd, S ← S + M
  - S ← S >> 1
- S is WIDTH+2 bits wide and never overflows. S < 2M holds at loop exit.
- FINAL: if S ≥ M then R ← S − M, else R ← S. R is truncated to WIDTH bits.
- `io_R` is registered and holds stable through DONE. The stall is unbounded while `io_out_ready` is low.
- Operand inputs are don't-care outside the accept cycle. Changes during LOOP have no effect.
- Illegal operands without the check (M even, A ≥ M, B ≥ M) produce an unspecified R. Handshake and timing remain correct.
- Reset at any point, including mid-LOOP or in DONE: state is IDLE next cycle, the partial result is discarded and no stale `io_out_valid` appears.

## Timing
- Reset values: `io_in_ready` = 1 (IDLE), `io_out_valid` = 0, `io_R` = 0, `io_err` = 0.
- Latency: operands are accepted at edge 0. `io_out_valid` is high after edge WIDTH+1, i.e. WIDTH+1 cycles.
- A result handshake at edge k gives `io_in_ready` high after edge k. There is no same-cycle result-drain plus new-accept; throughput is one operation per WIDTH+3 cycles with an always-ready consumer.
- `io_in_valid` held high while busy: the operands are not consumed until IDLE.

## Configuration
- `MONT_ERR_CHECK_EN` defined:
  - At the accept edge, the latched operands are checked for M[0] == 0, A ≥ M or B ≥ M.
  - On violation the core goes directly to DONE on the next cycle with `io_R` = 0 and `io_err` = 1.
  - `io_err` clears on the result handshake and on reset.
- Not defined: no `io_err` port, no comparators, and no bypass path.

## Structure
- Package `mont_pkg`:
  - state enum `mont_state_t` (IDLE, LOOP, FINAL, DONE)
  - default `MONT_WIDTH` = 128
  - function computing the iteration-counter width, $clog2(WIDTH)+1
- Sub-module `mont_iter`: the combinational single-iteration datapath (add a_i·B, conditional add M, shift). Inputs are S, B, M and a_i; output is the next S. It is instantiated once inside `montgomery_mul_serial`, which holds the FSM, counter, operand registers and final subtract.

## Test plan
- WIDTH=8, A=5, B=7, M=13, consumer always ready → `io_R`=1, `io_out_valid` high exactly 9 cycles after the accept edge.
- WIDTH=8, A=12, B=12, M=13 → `io_R`=3. Also A=0, B=9, M=13 → `io_R`=0.
- WIDTH=128, M=2^128−159, A=159, B=1 → `io_R`=1 after 129 cycles. Then back-to-back with `io_in_valid` held high → the second accept occurs exactly 1 cycle after the first result handshake.
- WIDTH=8, A=5, B=7, M=13:
  - hold `io_out_ready`=0 for 20 cycles → `io_R`=1 and `io_out_valid` stay stable, and `io_in_ready` stays 0
  - release `io_out_ready` → one handshake, then IDLE
- Assert `reset` for one cycle at LOOP iteration 4 → next cycle `io_in_ready`=1, `io_out_valid`=0, `io_R`=0. The subsequent operation A=5, B=7, M=13 yields 1.
- With `MONT_ERR_CHECK_EN`: M=12 (even) → `io_err`=1 and `io_R`=0 one cycle after accept. Then a legal M=13 operation gives `io_err`=0 and `io_R`=1.
